// File: rtl/ring_arb_pkg.sv
// Shared types and helpers for the ring round-robin arbiter.
// Helpers work on a fixed ARB_MAXN-wide vector; callers zero-extend their
// N-bit vectors in and size-cast the result back.
package ring_arb_pkg;

  localparam int ARB_MAXN = 32;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  // Rotate the low n bits of v left by one; bit n-1 wraps to bit 0.
  function automatic logic [ARB_MAXN-1:0] onehot_rotl(input logic [ARB_MAXN-1:0] v,
                                                      input int unsigned n);
    logic [ARB_MAXN-1:0] mask;
    mask = (n >= ARB_MAXN) ? '1 : ((ARB_MAXN'(1) << n) - ARB_MAXN'(1));
    return ((v << 1) | (v >> (n - 1))) & mask;
  endfunction

  // Binary index of the set bit of a one-hot vector; 0 for an all-zero vector.
  function automatic int unsigned onehot2bin(input logic [ARB_MAXN-1:0] v);
    int unsigned b;
    logic [ARB_MAXN-1:0] t;
    b = 0;
    for (int i = 0; i < ARB_MAXN; i++) begin
      t = v >> i;
      if (t[0]) b = unsigned'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/ring_rr_pick.sv
// Combinational round-robin pick: first set req bit at or above the one-hot
// ptr, wrapping past N-1 to 0. The request vector is duplicated; the low copy
// is masked to slots at/above ptr, so the lowest set bit of the doubled word
// is either the in-order winner or, if none, the wrapped winner in the high copy.
module ring_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] win
);

  localparam int W2 = 2 * N;

  logic [W2-1:0] dbl;
  logic [W2-1:0] iso;

  // ~(ptr - 1) keeps the ptr slot and everything above it.
  assign dbl = {req, req & ~(ptr - N'(1))};
  // Isolate the lowest set bit.
  assign iso = dbl & (~dbl + W2'(1));
  assign win = iso[N-1:0] | iso[W2-1:N];

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer. The winner
// keeps the grant until it releases or drops its request; the pointer then
// moves to one past the winner. One IDLE cycle always separates grants.
// Optional feature macro: ARB_TIMEOUT_EN adds a hold counter that force-revokes
// a grant after HOLD_MAX BUSY cycles and pulses timeout.
// Note: the owner's release pulse is on port "rel" ("release" is a reserved word).
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int HOLD_MAX = 16,
  localparam int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           rel,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic [N-1:0]   ptr,
  output logic           timeout
);

  if (N < 2 || HOLD_MAX < 1) begin : g_param_check
    $error("ring_rr_arbiter: N must be >= 2 and HOLD_MAX >= 1");
  end

  arb_state_t     state, state_nxt;
  logic [N-1:0]   win;
  logic [N-1:0]   gnt_nxt;
  logic [N-1:0]   ptr_nxt;
  logic [IDW-1:0] id_nxt;
  logic           busy;
  logic           owner_drop;
  logic           forced;
  logic           revoke;

  ring_rr_pick #(.N(N)) u_pick (
    .req (req),
    .ptr (ptr),
    .win (win)
  );

  assign busy       = (state == ARB_BUSY);
  assign owner_drop = ((gnt & req) == '0);

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);

  logic [CW-1:0] hold_cnt;
  logic          tmo_q;

  // The cycle in which the count would reach HOLD_MAX is the last one allowed.
  assign forced = busy && (hold_cnt == CW'(HOLD_MAX - 1));

  // Hold counter: zero while idle so it starts at 0 on entry to BUSY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       hold_cnt <= '0;
    else if (!busy) hold_cnt <= '0;
    else            hold_cnt <= hold_cnt + CW'(1);
  end

  // Timeout pulse only when the counter, not the owner, ended the grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmo_q <= 1'b0;
    else      tmo_q <= forced && !rel && !owner_drop;
  end

  assign timeout = tmo_q;
`else
  assign forced  = 1'b0;
  assign timeout = 1'b0;
`endif

  assign revoke = busy && (rel || owner_drop || forced);

  // Next-state, next grant and pointer update.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    id_nxt    = gnt_id;
    ptr_nxt   = ptr;
    case (state)
      ARB_IDLE: begin
        if (|req) begin
          state_nxt = ARB_BUSY;
          gnt_nxt   = win;
          id_nxt    = IDW'(onehot2bin(ARB_MAXN'(win)));
        end
      end
      ARB_BUSY: begin
        if (revoke) begin
          state_nxt = ARB_IDLE;
          gnt_nxt   = '0;
          id_nxt    = '0;
          ptr_nxt   = N'(onehot_rotl(ARB_MAXN'(gnt), N));
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
        gnt_nxt   = '0;
        id_nxt    = '0;
      end
    endcase
  end

  // State, grant and pointer registers; reset drops any grant immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ARB_IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      ptr       <= N'(1);
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= |gnt_nxt;
      gnt_id    <= id_nxt;
      ptr       <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Bench for ring_rr_arbiter (N=4, HOLD_MAX=4). A slot-index reference model
// tracks owner, priority slot and elapsed hold cycles; directed scenarios
// are followed by randomized request/release traffic.
module tb_ring_rr_arbiter;

  localparam int N        = 4;
  localparam int HOLD_MAX = 4;
  localparam int IDW      = $clog2(N);

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic           rel = 1'b0;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic [N-1:0]   ptr;
  logic           timeout;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  bit m_busy;
  int m_own;
  int m_ptr;
  int m_hold;
  bit m_tmo;

  ring_rr_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .rel       (rel),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .ptr       (ptr),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_own = 0; m_ptr = 0; m_hold = 0; m_tmo = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic rl);
    bit drop, expire;
    m_tmo = 0;
    if (!m_busy) begin
      for (int j = 0; j < N; j++) begin
        int idx;
        idx = (m_ptr + j) % N;
        if (r[idx]) begin
          m_own  = idx;
          m_busy = 1;
          m_hold = 0;
          break;
        end
      end
    end else begin
      drop = !r[m_own];
`ifdef ARB_TIMEOUT_EN
      expire = (m_hold + 1 == HOLD_MAX);
`else
      expire = 0;
`endif
      if (rl || drop || expire) begin
        m_tmo  = expire && !rl && !drop;
        m_ptr  = (m_own + 1) % N;
        m_busy = 0;
      end else begin
        m_hold++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] eg;
    eg = m_busy ? (32'd1 << m_own) : 32'd0;
    chk({tag, "_gnt"},   32'(gnt),       eg);
    chk({tag, "_vld"},   32'(gnt_valid), 32'(m_busy));
    chk({tag, "_id"},    32'(gnt_id),    m_busy ? 32'(m_own) : 32'd0);
    chk({tag, "_ptr"},   32'(ptr),       32'd1 << m_ptr);
    chk({tag, "_tmo"},   32'(timeout),   32'(m_tmo));
  endtask

  // One clock: drive inputs away from the edge, advance model, check after edge.
  task automatic cyc(input string tag, input logic [N-1:0] r, input logic rl);
    req = r;
    rel = rl;
    @(posedge clk);
    model_step(r, rl);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_all("rst");
    rst = 1'b1;

    // Full load: release two cycles after each grant.
    for (int g = 0; g < 5; g++) begin
      cyc("fl", 4'b1111, 1'b0);
      chk("fl_seq_id", 32'(gnt_id), 32'(g % 4));
      cyc("fl", 4'b1111, 1'b0);
      cyc("fl", 4'b1111, 1'b1);
      chk("fl_seq_ptr", 32'(ptr), 32'd1 << ((g + 1) % 4));
    end
    cyc("fl_idle", 4'b0000, 1'b0);

    // Single requester from ptr=0001.
    pulse_reset();
    cyc("single", 4'b0100, 1'b0);
    chk("single_gnt", 32'(gnt), 32'b0100);
    chk("single_id", 32'(gnt_id), 32'd2);
    cyc("single", 4'b0100, 1'b1);
    chk("single_rel_gnt", 32'(gnt), 32'd0);
    chk("single_rel_ptr", 32'(ptr), 32'b1000);

    // Wrap: ptr=1000 with req 0011 picks requester 0.
    cyc("wrap", 4'b0011, 1'b0);
    chk("wrap_gnt", 32'(gnt), 32'b0001);
    cyc("wrap", 4'b0011, 1'b1);
    chk("wrap_ptr", 32'(ptr), 32'b0010);
    cyc("wrap_idle", 4'b0000, 1'b0);

    // Owner withdraws, then a release in IDLE is ignored.
    cyc("wd", 4'b0100, 1'b0);
    cyc("wd", 4'b0100, 1'b0);
    cyc("wd", 4'b0000, 1'b0);
    chk("wd_gnt", 32'(gnt), 32'd0);
    chk("wd_ptr", 32'(ptr), 32'b1000);
    cyc("ign", 4'b0000, 1'b1);
    chk("ign_gnt", 32'(gnt), 32'd0);
    chk("ign_ptr", 32'(ptr), 32'b1000);

    // Asynchronous reset in the middle of a grant.
    cyc("mid", 4'b0010, 1'b0);
    chk("mid_gnt", 32'(gnt), 32'b0010);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("async_rst_hold");
    rst = 1'b1;

    // Hold limit: requester 1 never releases.
    cyc("hold", 4'b0010, 1'b0);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < HOLD_MAX - 1; i++) begin
      chk("tmo_held", 32'(gnt), 32'b0010);
      cyc("tmo", 4'b0010, 1'b0);
    end
    chk("tmo_held", 32'(gnt), 32'b0010);
    cyc("tmo", 4'b0010, 1'b0);
    chk("tmo_gnt", 32'(gnt), 32'd0);
    chk("tmo_pulse", 32'(timeout), 32'd1);
    chk("tmo_ptr", 32'(ptr), 32'b0100);
    cyc("tmo_after", 4'b0000, 1'b0);
    chk("tmo_once", 32'(timeout), 32'd0);
`else
    for (int i = 0; i < 20; i++) cyc("hold", 4'b0010, 1'b0);
    chk("hold_gnt", 32'(gnt), 32'b0010);
    chk("hold_tmo", 32'(timeout), 32'd0);
    cyc("hold_rel", 4'b0010, 1'b1);
`endif
    cyc("pre_rand", 4'b0000, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r;
      logic rl;
      r  = N'($urandom);
      rl = ($urandom_range(3) == 0);
      cyc("rand", r, rl);
      if (gnt_valid !== |gnt) chk("rand_vld_or", 32'(gnt_valid), 32'(|gnt));
      if ((gnt & (gnt - 1'b1)) != '0) chk("rand_onehot", 32'(gnt), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
